// File: rtl/ins_fetch_pkg.sv
// ---------------------------------------------------------------------------
// ins_fetch_pkg
// Shared definitions for the instruction fetch sequencer:
//   - fetch_state_e    : sequencer state encoding
//   - DEFAULT_HALT_INS : instruction encoding that stops fetching
// ---------------------------------------------------------------------------
package ins_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_OUT    = 3'd3,
        ST_HALTED = 3'd4
    } fetch_state_e;

    localparam logic [8:0] DEFAULT_HALT_INS = 9'h000;

endpackage

// File: rtl/ins_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// ins_fetch_ctrl
// Instruction fetch sequencer. Owns the program counter, issues one read at a
// time to an external instruction memory with a one-cycle registered read,
// captures the returned word and offers it to the decoder over valid/ready.
// Supports start at an address, jumps (immediate or pending), flush and
// halt-on-opcode.
//
// Ports:
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   start         begin fetching at start_addr (only in IDLE / HALTED)
//   start_addr    first program counter value
//   flush         synchronous abort back to IDLE
//   jmp_en        jump request, target on jmp_addr
//   PC_address    memory address (the pc register)
//   rEn           memory read enable, high only in READ
//   instruction   memory read data, valid the cycle after rEn
//   ins_out       captured instruction towards the decoder
//   ins_valid     ins_out is valid
//   ins_ready     decoder accepts ins_out
//   busy          sequencer active (not IDLE, not HALTED)
//   halted        halt instruction was retired
//   ins_count     handshakes since last start, saturating
// ---------------------------------------------------------------------------
module ins_fetch_ctrl
    import ins_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    INS_WIDTH  = 9,
    parameter logic [INS_WIDTH-1:0]  HALT_INS   = INS_WIDTH'(DEFAULT_HALT_INS),
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic                  flush,
    input  logic                  jmp_en,
    input  logic [ADDR_WIDTH-1:0] jmp_addr,
    output logic [ADDR_WIDTH-1:0] PC_address,
    output logic                  rEn,
    input  logic [INS_WIDTH-1:0]  instruction,
    output logic [INS_WIDTH-1:0]  ins_out,
    output logic                  ins_valid,
    input  logic                  ins_ready,
    output logic                  busy,
    output logic                  halted,
    output logic [CNT_WIDTH-1:0]  ins_count
);

    // Saturating increment for the retired-instruction counter.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [INS_WIDTH-1:0]  ir_p1, ir_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] tgt_q, tgt_d;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  hs;

    assign hs = (state_q == ST_OUT) && ins_ready;

    // A jump presented in the handshake cycle beats an older pending one;
    // otherwise fall through sequentially, wrapping at the top of memory.
    assign next_pc = jmp_en ? jmp_addr :
                     pend_q ? tgt_q    :
                              pc_q + ADDR_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_p1;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        tgt_d   = tgt_q;

        if (flush) begin
            state_d = ST_IDLE;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HALTED: begin
                    if (start) begin
                        state_d = ST_READ;
                        pc_d    = start_addr;
                        cnt_d   = '0;
                        pend_d  = 1'b0;
                    end
                end

                ST_READ: begin
                    state_d = ST_WAIT;
                    if (jmp_en) begin
                        pend_d = 1'b1;
                        tgt_d  = jmp_addr;
                    end
                end

                // Memory data is on the bus this cycle; capture it.
                ST_WAIT: begin
                    state_d = ST_OUT;
                    ir_d    = instruction;
                    if (jmp_en) begin
                        pend_d = 1'b1;
                        tgt_d  = jmp_addr;
                    end
                end

                ST_OUT: begin
                    if (hs) begin
                        cnt_d  = sat_inc(cnt_q);
                        pend_d = 1'b0;
                        // Halt wins over any jump; pc stays on the halt word.
                        if (ir_p1 == HALT_INS) begin
                            state_d = ST_HALTED;
                        end else begin
                            state_d = ST_READ;
                            pc_d    = next_pc;
                        end
                    end else if (jmp_en) begin
                        pend_d = 1'b1;
                        tgt_d  = jmp_addr;
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_p1   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_p1   <= ir_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            tgt_q   <= tgt_d;
        end
    end

    assign PC_address = pc_q;
    assign rEn        = (state_q == ST_READ);
    assign ins_out    = ir_p1;
    assign ins_valid  = (state_q == ST_OUT);
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_HALTED);
    assign halted     = (state_q == ST_HALTED);
    assign ins_count  = cnt_q;

endmodule

// File: tb/tb_ins_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ins_fetch_ctrl
// Directed bench for ins_fetch_ctrl. Two instances share all stimulus: one
// with a 16-bit counter, one with a 2-bit counter to observe saturation.
// Each instance has its own registered-read instruction memory model.
// ---------------------------------------------------------------------------
module tb_ins_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] start_addr;
    logic       flush;
    logic       jmp_en;
    logic [7:0] jmp_addr;
    logic       ins_ready;

    logic [7:0]  pc0, pc1;
    logic        ren0, ren1;
    logic [8:0]  rd0, rd1;
    logic [8:0]  iout0, iout1;
    logic        vld0, vld1;
    logic        busy0, busy1;
    logic        hlt0, hlt1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    logic [8:0] mem [0:255];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ins_fetch_ctrl #(.ADDR_WIDTH(8), .INS_WIDTH(9), .HALT_INS(9'h000), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .flush(flush), .jmp_en(jmp_en), .jmp_addr(jmp_addr),
        .PC_address(pc0), .rEn(ren0), .instruction(rd0), .ins_out(iout0),
        .ins_valid(vld0), .ins_ready(ins_ready), .busy(busy0), .halted(hlt0),
        .ins_count(cnt0)
    );

    ins_fetch_ctrl #(.ADDR_WIDTH(8), .INS_WIDTH(9), .HALT_INS(9'h000), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .flush(flush), .jmp_en(jmp_en), .jmp_addr(jmp_addr),
        .PC_address(pc1), .rEn(ren1), .instruction(rd1), .ins_out(iout1),
        .ins_valid(vld1), .ins_ready(ins_ready), .busy(busy1), .halted(hlt1),
        .ins_count(cnt1)
    );

    // Registered-read instruction memories.
    always @(posedge clk) begin
        if (ren0) rd0 <= mem[pc0];
        if (ren1) rd1 <= mem[pc1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [8:0] exp_ins [0:3];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 9'h100 | 9'(i);
        mem[8'h10] = 9'h101;
        mem[8'h11] = 9'h102;
        mem[8'h12] = 9'h103;
        mem[8'h13] = 9'h000;
        exp_ins[0] = 9'h101;
        exp_ins[1] = 9'h102;
        exp_ins[2] = 9'h103;
        exp_ins[3] = 9'h000;

        rst_n = 1'b0; start = 1'b0; start_addr = 8'h00; flush = 1'b0;
        jmp_en = 1'b0; jmp_addr = 8'h00; ins_ready = 1'b0;

        // Reset values
        tick();
        chk("rst_pc",    32'(pc0),   32'h0);
        chk("rst_ren",   32'(ren0),  32'h0);
        chk("rst_insout",32'(iout0), 32'h0);
        chk("rst_valid", 32'(vld0),  32'h0);
        chk("rst_busy",  32'(busy0), 32'h0);
        chk("rst_halted",32'(hlt0),  32'h0);
        chk("rst_count", 32'(cnt0),  32'h0);
        rst_n = 1'b1;
        tick();

        // Basic run 0x10..0x13 ending on a halt word, ready held high
        start = 1'b1; start_addr = 8'h10; ins_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            start = 1'b0;
            chk("run_ren",  32'(ren0), 32'h1);
            chk("run_pc",   32'(pc0),  32'h10 + 32'(k));
            chk("run_busy", 32'(busy0), 32'h1);
            tick();
            chk("run_wait_valid", 32'(vld0), 32'h0);
            tick();
            chk("run_valid",  32'(vld0),  32'h1);
            chk("run_insout", 32'(iout0), 32'(exp_ins[k]));
            chk("run_count",  32'(cnt0),  32'(k));
        end
        tick();
        chk("halt_halted", 32'(hlt0),  32'h1);
        chk("halt_busy",   32'(busy0), 32'h0);
        chk("halt_pc",     32'(pc0),   32'h13);
        chk("halt_count",  32'(cnt0),  32'h4);
        chk("sat_count",   32'(cnt1),  32'h3);

        // Backpressure from HALTED restart at 0x20
        start = 1'b1; start_addr = 8'h20; ins_ready = 1'b0;
        tick();
        start = 1'b0;
        chk("bp_ren",   32'(ren0), 32'h1);
        chk("bp_pc",    32'(pc0),  32'h20);
        chk("bp_count", 32'(cnt0), 32'h0);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",  32'(vld0),  32'h1);
            chk("bp_insout", 32'(iout0), 32'h120);
            chk("bp_pcfix",  32'(pc0),   32'h20);
            chk("bp_noren",  32'(ren0),  32'h0);
            chk("bp_cnt",    32'(cnt0),  32'h0);
            tick();
        end
        chk("bp_valid_end", 32'(vld0), 32'h1);
        ins_ready = 1'b1;
        tick();
        chk("bp_next_pc",  32'(pc0),  32'h21);
        chk("bp_next_ren", 32'(ren0), 32'h1);
        chk("bp_next_cnt", 32'(cnt0), 32'h1);

        // Jumps: pending last-wins, then jump in the handshake cycle
        ins_ready = 1'b0;
        tick();                              // WAIT
        jmp_en = 1'b1; jmp_addr = 8'h40;
        tick();                              // OUT
        jmp_addr = 8'h50;
        tick();                              // OUT, release
        jmp_en = 1'b0; ins_ready = 1'b1;
        tick();
        chk("jmp_pend_ren", 32'(ren0), 32'h1);
        chk("jmp_pend_pc",  32'(pc0),  32'h50);
        tick();
        tick();
        chk("jmp_insout", 32'(iout0), 32'h150);
        jmp_en = 1'b1; jmp_addr = 8'h60;
        tick();
        jmp_en = 1'b0;
        chk("jmp_hs_pc", 32'(pc0), 32'h60);
        tick();
        tick();
        tick();
        chk("jmp_clr_pc", 32'(pc0), 32'h61);
        chk("jmp_cnt",    32'(cnt0), 32'h4);
        chk("jmp_cnt_sat",32'(cnt1), 32'h3);

        // Flush in WAIT
        tick();                              // WAIT
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_busy",  32'(busy0), 32'h0);
        chk("fl_valid", 32'(vld0),  32'h0);
        chk("fl_pc",    32'(pc0),   32'h61);
        chk("fl_cnt",   32'(cnt0),  32'h4);
        jmp_en = 1'b1; jmp_addr = 8'h77;     // must be ignored in IDLE
        tick();
        jmp_en = 1'b0;
        chk("fl_idle_valid", 32'(vld0),  32'h0);
        chk("fl_idle_busy",  32'(busy0), 32'h0);

        // Restart at 0xFF, sequential wrap to 0x00
        start = 1'b1; start_addr = 8'hFF;
        tick();
        start = 1'b0;
        chk("wr_pc",  32'(pc0),  32'hFF);
        chk("wr_ren", 32'(ren0), 32'h1);
        tick();
        tick();
        chk("wr_insout", 32'(iout0), 32'h1FF);
        chk("wr_cnt",    32'(cnt0),  32'h0);
        tick();
        chk("wr_next_pc", 32'(pc0),  32'h00);
        chk("wr_next_cnt",32'(cnt0), 32'h1);

        // flush together with start: flush wins
        flush = 1'b1; start = 1'b1; start_addr = 8'h30;
        tick();
        flush = 1'b0; start = 1'b0;
        chk("fs_busy", 32'(busy0), 32'h0);
        chk("fs_pc",   32'(pc0),   32'h00);

        // Asynchronous reset while in OUT
        start = 1'b1; start_addr = 8'h10; ins_ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("ar_pre_valid",  32'(vld0),  32'h1);
        chk("ar_pre_insout", 32'(iout0), 32'h101);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_pc",     32'(pc0),   32'h0);
        chk("ar_ren",    32'(ren0),  32'h0);
        chk("ar_insout", 32'(iout0), 32'h0);
        chk("ar_valid",  32'(vld0),  32'h0);
        chk("ar_busy",   32'(busy0), 32'h0);
        chk("ar_halted", 32'(hlt0),  32'h0);
        chk("ar_count",  32'(cnt0),  32'h0);
        #2 rst_n = 1'b1;
        tick();
        chk("ar_post_busy", 32'(busy0), 32'h0);
        chk("ar_post_ren",  32'(ren0),  32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
